tx_module: RTL and testbench

TX_MODULE -- requirements
Module: tx_module

---
 rtl/uart_pkg.sv | 20 ++
 rtl/tx_module_if.sv | 12 +
 rtl/tx_baud_gen.sv | 29 ++
 rtl/tx_module.sv | 102 ++++++++++
 tb/tb_tx_module.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and parity helper.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tx_module_if.sv
// Byte producer handshake into the UART transmitter (valid/ready with data).
interface tx_module_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 valid;
  logic                 ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);

endinterface

// File: rtl/tx_baud_gen.sv
// Per-bit down-counter: reload starts a fresh bit period, bit_done pulses on its last cycle.
module tx_baud_gen #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic reload,
  output logic bit_done
);

  localparam int            CW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= RELOAD_VAL;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign bit_done = run && (cnt == '0);

endmodule

// File: rtl/tx_module.sv
// UART transmitter: one-byte holding register feeding a start/data/parity/stop frame sequencer.
module tx_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  tx_module_if.slave  bus,
  output logic        busy,
  output logic        tx
);

  logic [2:0]           state;
  logic [2:0]           bit_idx;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 bit_done;
  logic                 accept;
  logic                 load;

  assign accept    = bus.valid & ~hold_full;
  // A held byte is loaded from IDLE or straight out of STOP, so back-to-back frames have no gap.
  assign load      = hold_full & enable &
                     ((state == ST_IDLE) | ((state == ST_STOP) & bit_done));
  assign bus.ready = ~hold_full;
  assign busy      = (state != ST_IDLE);

  tx_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .run      (busy),
    .reload   (load | bit_done),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      hold_full <= 1'b0;
      tx        <= STOP_BIT;
    end else begin
      hold_full <= accept | (hold_full & ~load);
      if (load) begin
        state   <= ST_START;
        bit_idx <= '0;
        tx      <= START_BIT;
      end else if (bit_done) begin
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
          ST_DATA: begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                tx    <= par;
              end else begin
                state <= ST_STOP;
                tx    <= STOP_BIT;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
            tx    <= STOP_BIT;
          end
          default: begin
            state <= ST_IDLE;
            tx    <= STOP_BIT;
          end
        endcase
      end
    end
  end

  // Datapath registers carry no reset; their contents only matter once hold_full/state say so.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= bus.data_in;
    end
    if (load) begin
      shreg <= hold_data;
      par   <= even_parity(hold_data);
    end else if (bit_done && (state == ST_DATA)) begin
      shreg <= {1'b0, shreg[DATA_BITS-1:1]};
    end
  end

endmodule

// File: tb/tb_tx_module.sv
// Bench for tx_module: frame-level reference model checked every cycle plus literal frame checks.
module tb_tx_module;

  localparam int CPB  = 8;
  localparam int FLEN = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic busy_a, tx_a, busy_b, tx_b;

  tx_module_if bus_a ();
  tx_module_if bus_b ();

  tx_module #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_a), .busy(busy_a), .tx(tx_a));

  tx_module #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_b), .busy(busy_b), .tx(tx_b));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is a list of bit values, each shown for CPB cycles.
  logic       m_busy = 1'b0;
  logic       m_hold_v = 1'b0;
  logic [7:0] m_hold = '0;
  logic [7:0] m_byte = '0;
  int         m_pos = 0;
  logic       m_tx;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9) return ^b;
    return 1'b1;
  endfunction

  always_comb m_tx = m_busy ? frame_bit(m_byte, m_pos / CPB) : 1'b1;

  always @(posedge clk or negedge reset) begin : model
    logic       b, hv, acc;
    logic [7:0] h, cur;
    int         p;
    if (!reset) begin
      m_busy   <= 1'b0;
      m_hold_v <= 1'b0;
      m_pos    <= 0;
    end else begin
      b = m_busy; hv = m_hold_v; h = m_hold; cur = m_byte; p = m_pos;
      acc = bus_a.valid && !m_hold_v;
      if (b) begin
        p = p + 1;
        if (p == FLEN * CPB) b = 1'b0;
      end
      if (!b && hv && enable) begin
        b = 1'b1; p = 0; cur = h; hv = 1'b0;
      end
      if (acc) begin
        hv = 1'b1; h = bus_a.data_in;
      end
      m_busy <= b; m_hold_v <= hv; m_hold <= h; m_byte <= cur; m_pos <= p;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check($sformatf("model@%0t {tx,busy,ready}", $time),
            {29'd0, tx_a, busy_a, bus_a.ready}, {29'd0, m_tx, m_busy, !m_hold_v});
  end

  function automatic logic [31:0] seq(input string s);
    logic [31:0] v = '0;
    for (int i = 0; i < s.len(); i++) v[i] = (s[i] == 8'h31);
    return v;
  endfunction

  // Caller is at a negedge; returns at the negedge following acceptance.
  task automatic offer(input int sel, input logic [7:0] d);
    int n;
    if (sel == 0) begin bus_a.valid = 1'b1; bus_a.data_in = d; end
    else          begin bus_b.valid = 1'b1; bus_b.data_in = d; end
    for (n = 0; n < 400; n++) begin
      if ((sel == 0) ? bus_a.ready : bus_b.ready) break;
      @(negedge clk);
    end
    if (n >= 400) begin
      vectors++; miscompares++;
      $display("FAIL offer_timeout: ready stayed 0, expected 1");
    end
    @(negedge clk);
    if (sel == 0) bus_a.valid = 1'b0; else bus_b.valid = 1'b0;
  endtask

  task automatic capture(input int sel, output logic [31:0] bits, output int bcnt);
    int n, cyc;
    bits = '0;
    for (n = 0; n < 50 && !((sel == 0) ? busy_a : busy_b); n++) @(negedge clk);
    cyc = 0;
    while (((sel == 0) ? busy_a : busy_b) && cyc < 400) begin
      if ((cyc % CPB) == CPB / 2 && (cyc / CPB) < 32) bits[cyc / CPB] = (sel == 0) ? tx_a : tx_b;
      cyc++;
      @(negedge clk);
    end
    bcnt = cyc;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 400 && busy_a; n++) @(negedge clk);
    if (n >= 400) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: busy stayed 1, expected 0");
    end
  endtask

  logic [31:0] bits;
  int          bcnt;
  logic [7:0]  lb [3] = '{8'h00, 8'hFF, 8'h05};

  initial begin
    bus_a.valid = 1'b0; bus_a.data_in = '0;
    bus_b.valid = 1'b0; bus_b.data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_state {tx,busy,ready}", {tx_a, busy_a, bus_a.ready}, 32'b101);
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    fork offer(0, 8'hA5); capture(0, bits, bcnt); join
    check("A5_bits", bits, seq("01010010101"));
    check("A5_busy_cycles", bcnt, 88);

    for (int i = 0; i < 3; i++) begin
      fork offer(0, lb[i]); capture(0, bits, bcnt); join
      check($sformatf("loop_data_%0h", lb[i]), bits[8:1], lb[i]);
      check($sformatf("loop_parity_err_%0h", lb[i]), bits[9] ^ (^bits[8:1]), 0);
      check($sformatf("loop_start_stop_%0h", lb[i]), {bits[0], bits[10]}, 2'b01);
    end

    fork begin offer(0, 8'h3C); offer(0, 8'hC3); end capture(0, bits, bcnt); join
    check("b2b_bits", bits, seq("0001111000101100001101"));
    check("b2b_busy_cycles", bcnt, 176);

    enable = 1'b0;
    offer(0, 8'h69);
    repeat (20) @(negedge clk);
    check("held_disabled {tx,busy,ready}", {tx_a, busy_a, bus_a.ready}, 32'b100);
    enable = 1'b1;
    @(negedge clk);
    check("enable_start {tx,busy}", {tx_a, busy_a}, 32'b01);
    wait_idle();

    offer(0, 8'h81);
    offer(0, 8'h42);
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    check("midframe_disable {tx,busy,ready}", {tx_a, busy_a, bus_a.ready}, 32'b100);
    enable = 1'b1;
    @(negedge clk);
    check("held_resume_busy", busy_a, 1);
    wait_idle();

    offer(0, 8'h5A);
    repeat (20) @(negedge clk);
    check("pre_reset_busy", busy_a, 1);
    #2 reset = 1'b0;
    #1 check("async_reset {tx,busy,ready}", {tx_a, busy_a, bus_a.ready}, 32'b101);
    @(negedge clk);
    reset = 1'b1;
    repeat (120) @(negedge clk);
    check("post_reset_idle {tx,busy,ready}", {tx_a, busy_a, bus_a.ready}, 32'b101);

    fork offer(1, 8'h80); capture(1, bits, bcnt); join
    check("noparity_bits", bits, seq("0000000011"));
    check("noparity_busy_cycles", bcnt, 80);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
